uart_boot_loader: RTL and testbench

Firmware loader between the UART receive/transmit byte interface and the SoC program RAM write port. Holds the CPU in reset after power-up, accepts a framed image over the UART, writes it into RAM as 32-bit words, verifies a checksum, answers ACK/NAK, and releases the CPU on success. Lets the SoC boot without RAM preloading.

---
 rtl/loader_pkg.sv | 23 ++
 rtl/loader_timeout.sv | 34 +++
 rtl/uart_boot_loader.sv | 183 ++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the UART boot loader.
//   LoaderState : FSM state encoding, one state per frame field plus CHECK/RESP.
//   LDR_SYNC    : frame start byte.
//   LDR_ACK     : response byte for a load whose checksum matched.
//   LDR_NAK     : response byte for a checksum mismatch or an aborted frame.
package loader_pkg;

  typedef enum logic [2:0] {
    LS_IDLE    = 3'd0,
    LS_LEN_LO  = 3'd1,
    LS_LEN_HI  = 3'd2,
    LS_ADDR_LO = 3'd3,
    LS_ADDR_HI = 3'd4,
    LS_DATA    = 3'd5,
    LS_CHECK   = 3'd6,
    LS_RESP    = 3'd7
  } LoaderState;

  localparam logic [7:0] LDR_SYNC = 8'hA5;
  localparam logic [7:0] LDR_ACK  = 8'h06;
  localparam logic [7:0] LDR_NAK  = 8'h15;

endpackage

// File: rtl/loader_timeout.sv
// loader_timeout: inter-byte watchdog for the boot loader.
//   clk     : system clock.
//   reset   : asynchronous, active-high reset.
//   clear   : restart the count (a byte arrived).
//   enable  : count while a frame is in progress; the count is held at 0 otherwise.
//   expired : high while the count sits at TIMEOUT-1 and enable is high.
module loader_timeout #(
  parameter int TIMEOUT = 4_800_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  assign expired = enable && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || !enable) begin
      cnt <= '0;
    end else if (!expired) begin
      // Saturate so a stalled abort can never wrap back to a small count.
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a framed firmware image over a UART byte
// interface, writes it into program RAM as 32-bit words, checks an 8-bit
// additive checksum, answers ACK/NAK and releases the CPU on success.
//
// Frame: A5, LEN_LO, LEN_HI, ADDR_LO, ADDR_HI, LEN*4 data bytes (little-endian
// words), CSUM (mod-256 sum of the data bytes only).
//
// Ports:
//   clk, reset            : clock, asynchronous active-high reset.
//   rx_data, rx_valid     : received byte and its one-cycle strobe.
//   tx_data, tx_valid     : response byte and its one-cycle strobe.
//   tx_busy               : transmitter busy; tx_valid never pulses while high.
//   ram_addr/wdata/wmask  : RAM word write port, wmask is 4'h0 or 4'hF.
//   cpu_hold              : holds the CPU in reset while high.
//   done                  : one-cycle pulse on a successful load.
//   error                 : sticky NAK flag, cleared by the next SYNC.
//
// Handshakes: rx_valid is a pure strobe with no back-pressure, so every state
// that consumes a field accepts one byte in any cycle (back-to-back included);
// bytes arriving in RESP are dropped. On the transmit side the response is
// issued in the first cycle tx_busy is sampled low, as a single tx_valid pulse.
//
// Build option: define UART_BOOT_LOADER_TIMEOUT_EN to abort a stalled frame
// with a NAK after TIMEOUT idle cycles; without it a partial frame waits
// until reset.
module uart_boot_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 4_800_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_wmask,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  LoaderState        state;
  logic [15:0]       words_left;  // loaded from LEN, counts down per word
  logic [7:0]        addr_lo;
  logic [ADDR_W-1:0] addr_q;      // next word address to write
  logic [1:0]        byte_cnt;    // byte position within the current word
  logic [23:0]       word_sh;     // first three bytes of the word, LSB first
  logic [7:0]        csum;
  logic [7:0]        resp_q;
  logic [15:0]       addr_full;
  logic              expired;

  assign addr_full = {rx_data, addr_lo};

`ifdef UART_BOOT_LOADER_TIMEOUT_EN
  logic cnt_en;
  assign cnt_en = (state != LS_IDLE) && (state != LS_RESP);

  loader_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (rx_valid),
    .enable (cnt_en),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LS_IDLE;
      words_left <= '0;
      addr_lo    <= '0;
      addr_q     <= '0;
      byte_cnt   <= '0;
      word_sh    <= '0;
      csum       <= '0;
      resp_q     <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_wmask  <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      tx_valid  <= 1'b0;
      done      <= 1'b0;
      ram_wmask <= 4'h0;

      case (state)
        LS_IDLE: begin
          if (rx_valid && rx_data == LDR_SYNC) begin
            cpu_hold <= 1'b1;
            error    <= 1'b0;
            csum     <= '0;
            byte_cnt <= '0;
            state    <= LS_LEN_LO;
          end
        end
        LS_LEN_LO: begin
          if (rx_valid) begin
            words_left[7:0] <= rx_data;
            state           <= LS_LEN_HI;
          end
        end
        LS_LEN_HI: begin
          if (rx_valid) begin
            words_left[15:8] <= rx_data;
            state            <= LS_ADDR_LO;
          end
        end
        LS_ADDR_LO: begin
          if (rx_valid) begin
            addr_lo <= rx_data;
            state   <= LS_ADDR_HI;
          end
        end
        LS_ADDR_HI: begin
          if (rx_valid) begin
            addr_q <= addr_full[ADDR_W-1:0];
            state  <= (words_left == 16'd0) ? LS_CHECK : LS_DATA;
          end
        end
        LS_DATA: begin
          if (rx_valid) begin
            csum     <= csum + rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            word_sh  <= {rx_data, word_sh[23:8]};
            if (byte_cnt == 2'd3) begin
              ram_wdata  <= {rx_data, word_sh};
              ram_addr   <= addr_q;
              ram_wmask  <= 4'hF;
              addr_q     <= addr_q + ADDR_W'(1);  // wraps silently at the top
              words_left <= words_left - 16'd1;
              if (words_left == 16'd1) state <= LS_CHECK;
            end
          end
        end
        LS_CHECK: begin
          if (rx_valid) begin
            if (rx_data == csum) begin
              resp_q <= LDR_ACK;
            end else begin
              resp_q <= LDR_NAK;
              error  <= 1'b1;
            end
            state <= LS_RESP;
          end
        end
        LS_RESP: begin
          if (!tx_busy) begin
            tx_valid <= 1'b1;
            tx_data  <= resp_q;
            if (resp_q == LDR_ACK) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end
            state <= LS_IDLE;
          end
        end
        default: state <= LS_IDLE;
      endcase

      // A stalled frame is answered with NAK; a byte in the same cycle wins.
      if (expired && !rx_valid) begin
        resp_q <= LDR_NAK;
        error  <= 1'b1;
        state  <= LS_RESP;
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: self-checking bench for uart_boot_loader. Frames are
// built from a byte list; expected RAM writes and the expected response are
// derived from the frame rules (little-endian words, wrapping word address,
// mod-256 data checksum) and compared by a write scoreboard and per-frame checks.
module tb_uart_boot_loader;

  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              tx_busy = 1'b0;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_wmask;
  logic              cpu_hold;
  logic              done;
  logic              error;

  uart_boot_loader #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_busy  (tx_busy),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_wmask(ram_wmask),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int tx_cnt   = 0;
  logic [ADDR_W+31:0] exp_q[$];  // {word address, word data}
  logic [7:0]         dat_q[$];  // data bytes of the next frame

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write and response monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_valid) tx_cnt++;
      if (done && !tx_valid) check("done_without_tx", done, 1'b0);
      if (ram_wmask != 4'h0) begin
        check("wmask", ram_wmask, 4'hF);
        if (exp_q.size() == 0) begin
          check("extra_write", ram_wmask, 4'h0);
        end else begin
          logic [ADDR_W+31:0] e;
          e = exp_q.pop_front();
          check("wr_addr", ram_addr, e[ADDR_W+31:32]);
          check("wr_data", ram_wdata, e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input bit b2b);
    if (!b2b) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom_range(0, 255));
      end
    end
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic wait_tx(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (tx_valid) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) check("resp_timeout", tx_valid, 1'b1);
  endtask

  // Sends one frame and checks writes, response, done, cpu_hold and error.
  // dat_q supplies the data bytes; it is filled randomly when empty.
  task automatic run_frame(input int len, input logic [15:0] addr, input bit bad,
                           input bit b2b, input int busy);
    logic [7:0]        sum;
    logic [7:0]        csum_b;
    logic [31:0]       word;
    logic [ADDR_W-1:0] wa;
    int                cyc;
    int                tx_before;
    bit                ack;

    if (dat_q.size() == 0)
      for (int i = 0; i < len * 4; i++) dat_q.push_back(8'($urandom_range(0, 255)));

    sum = 8'h00;
    for (int i = 0; i < len * 4; i++) sum = sum + dat_q[i];
    csum_b = bad ? sum + 8'h01 : sum;
    ack    = !bad;

    for (int w = 0; w < len; w++) begin
      word = {dat_q[4*w+3], dat_q[4*w+2], dat_q[4*w+1], dat_q[4*w]};
      wa   = ADDR_W'((int'(addr) + w) % (1 << ADDR_W));
      exp_q.push_back({wa, word});
    end

    tx_busy = (busy > 0);
    send_byte(8'hA5, b2b);
    @(negedge clk);
    rx_valid = 1'b0;
    check("sync_clears_error", error, 1'b0);
    check("sync_holds_cpu", cpu_hold, 1'b1);

    send_byte(8'(len), b2b);
    send_byte(8'(len >> 8), b2b);
    send_byte(addr[7:0], b2b);
    send_byte(addr[15:8], b2b);
    for (int i = 0; i < len * 4; i++) send_byte(dat_q[i], b2b);
    send_byte(csum_b, b2b);
    @(negedge clk);
    rx_valid  = 1'b0;
    tx_before = tx_cnt;

    if (busy > 0) begin
      for (int i = 0; i < busy; i++) begin
        @(negedge clk);
        check("tx_while_busy", tx_valid, 1'b0);
        // A stray SYNC during the response phase must be dropped.
        rx_data  = 8'hA5;
        rx_valid = (i == 5);
      end
      tx_busy = 1'b0;
      rx_valid = 1'b0;
    end

    wait_tx(cyc);
    check("tx_latency", cyc, 1);
    check("tx_data", tx_data, ack ? 8'h06 : 8'h15);
    check("done", done, ack);
    check("cpu_hold", cpu_hold, !ack);
    check("error", error, !ack);
    repeat (3) @(negedge clk);
    check("tx_count", tx_cnt - tx_before, 1);
    check("writes_left", exp_q.size(), 0);
    dat_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int tx_before;

    repeat (3) @(negedge clk);
    check("rst_cpu_hold", cpu_hold, 1'b1);
    check("rst_wmask", ram_wmask, 4'h0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_ram_addr", ram_addr, '0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Known image: words 0x0010=0x12345678, 0x0011=0xDEADBEEF.
    dat_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_frame(2, 16'h0010, 1'b0, 1'b1, 0);
    dat_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_frame(2, 16'h0010, 1'b1, 1'b0, 0);

    // Address wrap at the top of RAM, then an empty image.
    run_frame(2, 16'h3FFF, 1'b0, 1'b1, 0);
    run_frame(0, 16'h1234, 1'b0, 1'b0, 0);

    // Response held off by a busy transmitter.
    run_frame(1, 16'($urandom_range(0, 65535)), 1'b0, 1'b0, 20);

    // Reset in the middle of a frame: no response, registers back to reset.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    check("midrst_cpu_hold", cpu_hold, 1'b1);
    check("midrst_ram_addr", ram_addr, '0);
    check("midrst_ram_wdata", ram_wdata, 32'h0);
    check("midrst_tx_data", tx_data, 8'h00);
    reset     = 1'b0;
    tx_before = tx_cnt;
    repeat (10) @(negedge clk);
    check("midrst_no_tx", tx_cnt - tx_before, 0);
    run_frame(1, 16'h0100, 1'b0, 1'b0, 0);

`ifdef UART_BOOT_LOADER_TIMEOUT_EN
    // Stall after LEN_LO: NAK after 16 idle cycles, then SYNC clears error.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    @(negedge clk);
    rx_valid = 1'b0;
    wait_tx(cyc);
    check("timeout_latency", cyc, 17);
    check("timeout_tx_data", tx_data, 8'h15);
    check("timeout_error", error, 1'b1);
    check("timeout_cpu_hold", cpu_hold, 1'b1);
    check("timeout_done", done, 1'b0);
    repeat (2) @(negedge clk);
    run_frame(0, 16'h0000, 1'b0, 1'b0, 0);
`endif

    // Random frames: lengths, addresses near the wrap point, bad checksums.
    for (int k = 0; k < 10; k++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 65535))
                                       : 16'(16'h3FFC + $urandom_range(0, 3));
      run_frame($urandom_range(0, 5), a, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0);
    end

    cyc = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
